// File: rtl/nco_pkg.sv
// Shared types and constants for the multi-channel NCO generator.
package nco_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        OFF    = 2'd3
    } mode_e;

endpackage : nco_pkg

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, shadow/pending tuning update committed
// at carry-out, and registered waveform/wrap outputs.
module nco_channel
    import nco_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [ACC_W-1:0] cfg_tune,
    input  mode_e            cfg_mode,
    input  logic             cfg_sync,
    output logic             pending,
    output logic             sq,
    output logic [OUT_W-1:0] wave,
    output logic             wrap
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] tune_q, tune_d;
    mode_e            mode_q, mode_d;
    logic [ACC_W-1:0] sh_tune_q, sh_tune_d;
    mode_e            sh_mode_q, sh_mode_d;
    logic             pending_q, pending_d;
    logic [OUT_W-1:0] wave_q, wave_d;
    logic             wrap_q, wrap_d;

    logic             running;
    logic [ACC_W:0]   sum;
    logic             carry;

    // Step is tune + 1, so a zero tuning word still advances the phase.
    assign running = enable && (mode_q != OFF);
    assign sum     = {1'b0, acc_q} + {1'b0, tune_q} + {{ACC_W{1'b0}}, 1'b1};
    assign carry   = running && sum[ACC_W];

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        acc_d     = acc_q;
        tune_d    = tune_q;
        mode_d    = mode_q;
        sh_tune_d = sh_tune_q;
        sh_mode_d = sh_mode_q;
        pending_d = pending_q;
        wave_d    = '0;
        wrap_d    = carry;

        case (mode_q)
            SQUARE:  wave_d = {OUT_W{acc_q[ACC_W-1]}};
            SAW:     wave_d = acc_q[ACC_W-1 -: OUT_W];
            TRI:     wave_d = acc_q[ACC_W-2 -: OUT_W] ^ {OUT_W{acc_q[ACC_W-1]}};
            default: wave_d = '0;
        endcase

        if (mode_q == OFF) begin
            acc_d = '0;
        end else if (running) begin
            acc_d = sum[ACC_W-1:0];
        end

        // Commit lands on the carry edge itself, so the old step finishes its period.
        if (pending_q && (carry || !running)) begin
            tune_d    = sh_tune_q;
            mode_d    = sh_mode_q;
            pending_d = 1'b0;
        end

        // cfg_we only fires while pending_q is low, so it never collides with a commit.
        if (cfg_we) begin
            if (cfg_sync) begin
                tune_d = cfg_tune;
                mode_d = cfg_mode;
                acc_d  = '0;
                wrap_d = 1'b0;
            end else begin
                sh_tune_d = cfg_tune;
                sh_mode_d = cfg_mode;
                pending_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            tune_q    <= '0;
            mode_q    <= SQUARE;
            sh_tune_q <= '0;
            sh_mode_q <= SQUARE;
            pending_q <= 1'b0;
            wave_q    <= '0;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            tune_q    <= tune_d;
            mode_q    <= mode_d;
            sh_tune_q <= sh_tune_d;
            sh_mode_q <= sh_mode_d;
            pending_q <= pending_d;
            wave_q    <= wave_d;
            wrap_q    <= wrap_d;
        end
    end

    assign pending = pending_q;
    assign sq      = acc_q[ACC_W-1];
    assign wave    = wave_q;
    assign wrap    = wrap_q;

endmodule : nco_channel

// File: rtl/multi_channel_nco_gen.sv
// Multi-channel NCO: config write decode, per-channel ready mux and output
// packing around NCH nco_channel instances.
module multi_channel_nco_gen
    import nco_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int NCH   = 4,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_W-1:0]     cfg_tune,
    input  logic [MODE_W-1:0]    cfg_mode,
    input  logic                 cfg_sync,
    output logic [NCH-1:0]       sq_out,
    output logic [NCH*OUT_W-1:0] wave_out,
    output logic [NCH-1:0]       wrap
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] cfg_we;

    // Indices beyond NCH read as ready; writes to them are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                cfg_ready = ~pending[c];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign cfg_we[c] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));

        nco_channel #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable),
            .cfg_we   (cfg_we[c]),
            .cfg_tune (cfg_tune),
            .cfg_mode (mode_e'(cfg_mode)),
            .cfg_sync (cfg_sync),
            .pending  (pending[c]),
            .sq       (sq_out[c]),
            .wave     (wave_out[c*OUT_W +: OUT_W]),
            .wrap     (wrap[c])
        );
    end

endmodule : multi_channel_nco_gen

// File: tb/tb_multi_channel_nco_gen.sv
// Scoreboard bench for multi_channel_nco_gen: a phase-arithmetic model predicts
// every cycle's outputs; a separate monitor pops and compares them.
module tb_multi_channel_nco_gen;

    localparam int ACC_W = 16;
    localparam int OUT_W = 8;
    localparam int NCH   = 4;
    localparam int CH_W  = 2;
    localparam int MOD   = 1 << ACC_W;
    localparam int HALF  = 1 << (ACC_W - 1);

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_ch;
    logic [ACC_W-1:0]     cfg_tune;
    logic [1:0]           cfg_mode;
    logic                 cfg_sync;
    logic [NCH-1:0]       sq_out;
    logic [NCH*OUT_W-1:0] wave_out;
    logic [NCH-1:0]       wrap;

    multi_channel_nco_gen #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .NCH   (NCH),
        .CH_W  (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_tune  (cfg_tune),
        .cfg_mode  (cfg_mode),
        .cfg_sync  (cfg_sync),
        .sq_out    (sq_out),
        .wave_out  (wave_out),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_phase   [NCH];
    int m_tune    [NCH];
    int m_mode    [NCH];
    int m_sh_tune [NCH];
    int m_sh_mode [NCH];
    bit m_pend    [NCH];
    int m_wave    [NCH];
    bit m_wrap    [NCH];

    typedef struct {
        logic [NCH-1:0]       sq;
        logic [NCH*OUT_W-1:0] wave;
        logic [NCH-1:0]       wrap;
        logic                 ready;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int wave_of(int ph, int md);
        case (md)
            0: return (ph >= HALF) ? 255 : 0;
            1: return ph / 256;
            2: return (ph < HALF) ? (ph / 128) % 256 : 255 - (ph / 128) % 256;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0;   m_tune[c] = 0;    m_mode[c] = 0;
            m_sh_tune[c] = 0; m_sh_mode[c] = 0; m_pend[c] = 0;
            m_wave[c] = 0;    m_wrap[c] = 0;
        end
    endtask

    function automatic bit model_carries(int c);
        return (m_mode[c] != 3) && (m_phase[c] + m_tune[c] + 1 >= MOD);
    endfunction

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            bit run    = enable && (m_mode[c] != 3);
            int total  = m_phase[c] + m_tune[c] + 1;
            bit carry  = run && (total >= MOD);
            bit accept = cfg_valid && !m_pend[c] && (int'(cfg_ch) == c);
            m_wave[c] = wave_of(m_phase[c], m_mode[c]);
            m_wrap[c] = carry;
            if (m_mode[c] == 3)
                m_phase[c] = 0;
            else if (run)
                m_phase[c] = total % MOD;
            if (m_pend[c] && (carry || !run)) begin
                m_tune[c] = m_sh_tune[c];
                m_mode[c] = m_sh_mode[c];
                m_pend[c] = 0;
            end
            if (accept) begin
                if (cfg_sync) begin
                    m_tune[c]  = int'(cfg_tune);
                    m_mode[c]  = int'(cfg_mode);
                    m_phase[c] = 0;
                    m_wrap[c]  = 0;
                end else begin
                    m_sh_tune[c] = int'(cfg_tune);
                    m_sh_mode[c] = int'(cfg_mode);
                    m_pend[c]    = 1;
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            e.sq[c]              = (m_phase[c] >= HALF);
            e.wave[c*OUT_W +: 8] = 8'(m_wave[c]);
            e.wrap[c]            = m_wrap[c];
        end
        e.ready = !m_pend[int'(cfg_ch)];
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, expv);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sq_out",    32'(sq_out),    32'(e.sq));
                check("wave_out",  wave_out,       e.wave);
                check("wrap",      32'(wrap),      32'(e.wrap));
                check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic en, input logic v, input int ch,
                        input int tn, input int md, input logic sy);
        @(negedge clk);
        rst       = r;
        enable    = en;
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_tune  = ACC_W'(tn);
        cfg_mode  = 2'(md);
        cfg_sync  = sy;
        push_expected();
        model_edge();
    endtask

    task automatic idle(input int n, input logic en, input int probe_ch);
        for (int i = 0; i < n; i++) step(1'b1, en, 1'b0, probe_ch, 0, 0, 1'b0);
    endtask

    initial begin
        bit found;
        rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_tune = '0; cfg_mode = '0; cfg_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        idle(2, 1'b1, 0);

        // ch0 SAW and ch1 TRI at step 0x4000
        step(1'b1, 1'b1, 1'b1, 0, 16'h3FFF, 1, 1'b1);
        idle(10, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 1, 16'h3FFF, 2, 1'b1);
        idle(10, 1'b1, 1);

        // Deferred update mid-period on ch0: old period completes, then step 0x8000
        idle(1, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 0, 16'h7FFF, 1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 0, 16'h1111, 0, 1'b0);
        idle(10, 1'b1, 0);

        // Write landing in the same cycle as a ch2 carry-out; ch3 write while ch2 pending
        step(1'b1, 1'b1, 1'b1, 2, 16'h1FFF, 1, 1'b1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (model_carries(2)) found = 1;
            else step(1'b1, 1'b1, 1'b0, 2, 0, 0, 1'b0);
        end
        check("ch2_carry_found", 32'(found), 32'd1);
        step(1'b1, 1'b1, 1'b1, 2, 16'h0FFF, 1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3, 16'h5555, 2, 1'b0);
        idle(30, 1'b1, 2);

        // Pending update while enable is low commits on the next edge
        step(1'b1, 1'b1, 1'b1, 1, 16'h2FFF, 1, 1'b0);
        idle(5, 1'b0, 1);
        idle(10, 1'b1, 1);

        // Reset with a pending OFF write discards it
        step(1'b1, 1'b1, 1'b1, 0, 16'h1234, 3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        idle(20, 1'b1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int tn;
            case ($urandom_range(0, 3))
                0: tn = 16'h3FFF;
                1: tn = 16'h7FFF;
                2: tn = int'($urandom_range(16'h0FFF, 16'hFFFF));
                default: tn = int'($urandom_range(0, 16'hFFFF));
            endcase
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, NCH - 1)),
                 tn,
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1));
        end

        // Zero tuning word SQUARE: +1 per cycle, 10-cycle enable gap stretches the period
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b1);
        idle(16000, 1'b1, 0);
        idle(10, 1'b0, 0);
        idle(17000, 1'b1, 0);

        @(negedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multi_channel_nco_gen

// File: doc/multi_channel_nco_gen.md
# multi_channel_nco_gen

Multi-channel numerically controlled oscillator; next generation of the single-channel phase-accumulator frequency generator. Each of NCH channels has its own tuning word, waveform mode (square/saw/triangle/off) and glitch-free frequency update committed at the channel's phase wrap. Configuration arrives over a valid/ready write port from the control logic. Square, multi-bit waveform and wrap-strobe outputs feed the downstream DAC/PWM stage.

## Interface
- ACC_W, 16: phase accumulator width per channel (>= OUT_W+1)
- OUT_W, 8: waveform sample width
- NCH, 4: channel count (>= 1)
- CH_W, $clog2(NCH) (min 1): channel index width, derived
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- enable  in  1  global run; low holds all accumulators
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready
- cfg_ch  in  CH_W  target channel
- cfg_tune  in  ACC_W  tuning word; step = cfg_tune + 1
- cfg_mode  in  2  waveform mode
- cfg_sync  in  1  1 = apply immediately and clear phase
- sq_out  out  NCH  per-channel square (accumulator MSB)
- wave_out  out  NCH*OUT_W  per-channel sample, channel c at [c*OUT_W +: OUT_W]
- wrap  out  NCH  one-cycle strobe per channel on accumulator carry-out

## Operation
- Per channel: acc (ACC_W), active tune/mode, shadow tune/mode, pending flag.
- Accumulate when enable=1 and mode!=OFF: acc <= acc + tune + 1, modulo 2^ACC_W; carry-out asserts wrap next cycle. Zero tuning word still advances by 1.
- Modes: SQUARE=0 wave = {OUT_W{acc MSB}}; SAW=1 wave = acc[ACC_W-1 -: OUT_W]; TRI=2 wave = acc[ACC_W-2 -: OUT_W] if MSB=0 else its bitwise inverse; OFF=3 acc forced 0, wave 0, sq 0, no wrap.
- cfg_ready = ~pending[cfg_ch] (combinational from registers and cfg_ch).
- Accepted write, cfg_sync=0: load shadow, set pending. Commit shadow->active on the cycle the channel's carry-out occurs, or on the next edge if the channel is not accumulating (enable=0 or active mode OFF); clear pending on commit.
- Accepted write, cfg_sync=1: load active directly, acc <= 0, no wrap strobe, pending unchanged (stays 0).
- Write accepted in the same cycle as a carry-out: commits at the following wrap, not the current one.
- Reset: acc=0, active/shadow tune=0, mode=SQUARE, pending=0; all outputs 0, cfg_ready=1.
- Reset mid-operation discards pending updates; no partial commit.

## Timing
- sq_out driven directly from acc MSB register: 0 cycles after acc update.
- wave_out and wrap registered: 1 cycle after the acc value they reflect.
- Committed tuning takes effect on the first accumulation after the commit edge; a frequency change never truncates a period.
- cfg_sync write: acc reads 0 at edge+1, wave_out 0-based sample at edge+2.
- enable deassert: acc frozen from next edge; outputs hold last values.

## Structure
- Package nco_pkg: mode_e enum (SQUARE, SAW, TRI, OFF), MODE_W=2 constant.
- Sub-module nco_channel (accumulator, shadow/pending logic, waveform mapping), instantiated NCH times via generate; top holds cfg decode, cfg_ready mux and output packing.

## Test plan
- Reset, ch0 SAW, cfg_tune=0x3FFF, sync=1 -> wave_out[7:0] cycles 0x00,0x40,0x80,0xC0; wrap[0] every 4th cycle.
- ch1 TRI, cfg_tune=0x3FFF, sync=1 -> samples 0x00,0x80,0xFF,0x7F repeating; sq_out[1] 0,0,1,1.
- ch0 running step 0x4000, write cfg_tune=0x7FFF sync=0 mid-period -> cfg_ready low until next wrap, old period completes, then wrap every 2 cycles.
- cfg_tune=0x0000 SQUARE -> acc increments by 1; sq_out toggles every 32768 cycles; enable=0 for 10 cycles stretches period by exactly 10.
- Write with cfg_valid on same cycle as ch2 carry-out -> new tuning applied at following wrap only; write to ch3 while ch2 pending accepted (cfg_ready=1).
- rst low while pending=1 and mode OFF written -> all outputs 0, cfg_ready=1, pending cleared, ch restarts SQUARE with tune 0.
